pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
Plays back a siteswap pattern that the validity checker has already accepted. On every beat tick it emits the throw height, the identity of the ball being thrown, and the pattern position. It keeps a landing timetable so that ball identities are assigned and tracked automatically. The block sits between pattern entry/validation and the downstream display and animation logic.

Parameters:
MAX_HEIGHT, 7, largest throw value; also the landing-table depth in slots.
MAX_BALLS, 7, largest number of distinct balls; ball ids run 0..MAX_BALLS-1.

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
pattern_in  input  [2:0] x [6:0] unpacked  throw values; entry j is the j-th throw
pattern_length  input  3  number of used entries, legal range 1..7
pattern_valid_in  input  1  validity flag from the pattern checker
start_in  input  1  one-cycle request to latch the pattern and begin
stop_in  input  1  one-cycle request to abort and return to idle
beat_in  input  1  one-cycle beat tick
busy_out  output  1  high in RUN
fault_out  output  1  high in FAULT
start_err_out  output  1  one-cycle pulse when a start is rejected
throw_valid_out  output  1  one-cycle pulse per processed beat
throw_height_out  output  3  throw value for the processed beat
throw_ball_out  output  3  id of the thrown ball; 0 when throw_empty_out is high
throw_empty_out  output  1  high when the beat's throw value is 0 (empty hand)
throw_index_out  output  3  pattern position of the processed beat
num_balls_out  output  3  number of distinct balls introduced so far

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: all outputs are 0. State is IDLE. The landing table is cleared. The index and ball counters are 0.
- States: IDLE, RUN, FAULT.
- Start, IDLE to RUN:
  - Accepted when start_in is high, pattern_valid_in is high and pattern_length is nonzero.
  - On acceptance: latch pattern_in and pattern_length into internal registers; clear the table; set index to 0 and next_ball to 0.
  - Any other start_in in IDLE is rejected: pulse start_err_out for 1 cycle and stay in IDLE.
  - start_in is ignored in RUN and FAULT.
- Landing table: slots 0..MAX_HEIGHT-1, each holding {occ, ball_id}. Slot k holds the ball that lands k beats from now.
- Beat processing (RUN, beat_in high). Let h = latched[index].
  - Landing ball: if slot0 is occupied, the thrower is slot0.ball_id.
  - New ball: if slot0 is empty and h>0, the thrower is next_ball, and next_ball increments.
  - Shift: slot[k] <= slot[k+1] for k<MAX_HEIGHT-1; the top slot is cleared.
  - Placement: if h>0, the thrower is written into post-shift slot h-1.
  - Index advances modulo the latched length.
- Outputs are registered with 1-cycle latency. On the cycle after beat_in, throw_valid_out=1 and height, ball, empty and index describe that beat. num_balls_out tracks next_ball.
- Faults: the beat that hits any of these conditions enters FAULT and updates no outputs except fault_out, which becomes 1 on the next cycle.
  - Placement target already occupied (collision).
  - h==0 while slot0 is occupied (a dropped ball).
  - A new ball is needed while next_ball==MAX_BALLS.
- FAULT holds until stop_in or rst_in.
- stop_in in any state returns to IDLE on the next cycle and clears the table, the counters and fault_out. stop_in takes priority over a simultaneous beat_in.
- beat_in outside RUN is ignored. Beats are assumed at least 2 cycles apart; a back-to-back beat is still processed in order, one per cycle.
- Reset mid-RUN aborts immediately; no throw_valid_out pulse follows.

Optional Feature:
LANDING_MASK_EN
- When defined: adds the output landing_mask_out [MAX_HEIGHT-1:0], the registered post-beat occ vector of the table (bit k = slot k), for the animation lookahead. It resets to 0.
- When undefined: the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package juggle_pkg holds:
  - the constants MAX_HEIGHT, MAX_BALLS, THROW_W=3 and PATTERN_LEN=7;
  - the typedef slot_t {logic occ; logic [2:0] ball_id};
  - the typedef seq_state_t enum {IDLE, RUN, FAULT}.
- One natural sub-module, landing_table: it performs the shift, placement and collision detection, with inputs shift_en, place_h and place_ball, and outputs slot0 and collide.

Test Plan:
- Pattern "3", length 1, then 7 beats -> heights 3,3,... and balls 0,1,2,0,1,2,0; num_balls_out=3; fault_out stays 0.
- Pattern "531", length 3, 6 beats -> heights 5,3,1,5,3,1; balls 0,1,2,2,1,0; index 0,1,2,0,1,2; num_balls_out=3.
- Pattern "501", length 3, with pattern_valid_in=1, then 3 beats:
  - beat 1 (h=0, slot0 empty) -> throw_empty_out=1, throw_ball_out=0;
  - the third throw (h=1) introduces ball 1;
  - num_balls_out=2.
- Pattern "21", length 2, with pattern_valid_in forced to 1 -> the beat-1 placement collides; fault_out=1 one cycle later; busy_out=0; later beats produce no throw_valid_out; stop_in returns to IDLE with all outputs 0.
- start_in with pattern_valid_in=0, or with pattern_length=0 -> start_err_out pulses 1 cycle; state stays IDLE; busy_out=0.
- Running "3": assert stop_in in the same cycle as beat_in -> no throw_valid_out; IDLE next cycle. Then assert rst_in mid-RUN of "531" -> all outputs 0 on the next cycle, and a restart begins again at ball 0, index 0.

Source files
------------

// File: rtl/juggle_pkg.sv
// Shared constants and types for the siteswap pattern sequencer and its landing table.
package juggle_pkg;
    localparam int MAX_HEIGHT  = 7;
    localparam int MAX_BALLS   = 7;
    localparam int THROW_W     = 3;
    localparam int PATTERN_LEN = 7;

    typedef struct packed {
        logic         occ;
        logic [2:0]   ball_id;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } seq_state_t;
endpackage

// File: rtl/pattern_sequencer_if.sv
// Signal bundle between pattern entry/display logic and pattern_sequencer.
// landing_mask_out exists only when LANDING_MASK_EN is defined.
interface pattern_sequencer_if;
    import juggle_pkg::*;

    logic [THROW_W-1:0] pattern_in [PATTERN_LEN-1:0];
    logic [2:0]         pattern_length;
    logic               pattern_valid_in;
    logic               start_in;
    logic               stop_in;
    logic               beat_in;

    logic               busy_out;
    logic               fault_out;
    logic               start_err_out;
    logic               throw_valid_out;
    logic [2:0]         throw_height_out;
    logic [2:0]         throw_ball_out;
    logic               throw_empty_out;
    logic [2:0]         throw_index_out;
    logic [2:0]         num_balls_out;
    seq_state_t         state_dbg;
`ifdef LANDING_MASK_EN
    logic [MAX_HEIGHT-1:0] landing_mask_out;
`endif

    // Single-cycle pulses throughout: start_in, stop_in and beat_in are sampled
    // for one clock; throw_valid_out qualifies the throw_* fields for one clock.
    modport master (
        output pattern_in, pattern_length, pattern_valid_in, start_in, stop_in, beat_in,
        input  busy_out, fault_out, start_err_out, throw_valid_out, throw_height_out,
        input  throw_ball_out, throw_empty_out, throw_index_out, num_balls_out, state_dbg
`ifdef LANDING_MASK_EN
        , input landing_mask_out
`endif
    );

    modport slave (
        input  pattern_in, pattern_length, pattern_valid_in, start_in, stop_in, beat_in,
        output busy_out, fault_out, start_err_out, throw_valid_out, throw_height_out,
        output throw_ball_out, throw_empty_out, throw_index_out, num_balls_out, state_dbg
`ifdef LANDING_MASK_EN
        , output landing_mask_out
`endif
    );
endinterface

// File: rtl/landing_table.sv
// Landing timetable: slot k holds the ball landing k beats from now. Shifts one slot
// per beat, places the thrower at post-shift slot h-1 and flags placement collisions.
module landing_table
    import juggle_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               clear_in,
    input  logic               shift_en,
    input  logic [THROW_W-1:0] place_h,
    input  logic [2:0]         place_ball,
    output slot_t              slot0,
    output logic               collide
`ifdef LANDING_MASK_EN
    , output logic [MAX_HEIGHT-1:0] occ_mask
`endif
);
    slot_t              slots_q [MAX_HEIGHT];
    slot_t              slots_d [MAX_HEIGHT];
    slot_t              shifted [MAX_HEIGHT];
    logic [THROW_W-1:0] tgt;

    always_comb begin
        for (int k = 0; k < MAX_HEIGHT - 1; k++) begin
            shifted[k] = slots_q[k+1];
        end
        shifted[MAX_HEIGHT-1] = '0;
        tgt     = place_h - 3'd1;
        collide = (place_h != '0) && shifted[tgt].occ;
    end

    always_comb begin
        for (int k = 0; k < MAX_HEIGHT; k++) begin
            slots_d[k] = slots_q[k];
        end
        if (clear_in) begin
            for (int k = 0; k < MAX_HEIGHT; k++) begin
                slots_d[k] = '0;
            end
        end else if (shift_en) begin
            for (int k = 0; k < MAX_HEIGHT; k++) begin
                slots_d[k] = shifted[k];
            end
            if (place_h != '0) begin
                slots_d[tgt] = '{occ: 1'b1, ball_id: place_ball};
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int k = 0; k < MAX_HEIGHT; k++) begin
                slots_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < MAX_HEIGHT; k++) begin
                slots_q[k] <= slots_d[k];
            end
        end
    end

    assign slot0 = slots_q[0];

`ifdef LANDING_MASK_EN
    always_comb begin
        for (int k = 0; k < MAX_HEIGHT; k++) begin
            occ_mask[k] = slots_q[k].occ;
        end
    end
`endif
endmodule

// File: rtl/pattern_sequencer.sv
// Plays back a validated siteswap pattern one throw per beat, tracking ball identities.
// Define LANDING_MASK_EN to expose the landing-table occupancy as landing_mask_out.
module pattern_sequencer
    import juggle_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    pattern_sequencer_if.slave bus
);
    seq_state_t         state_q, state_d;
    logic [THROW_W-1:0] pat_q [PATTERN_LEN-1:0];
    logic [THROW_W-1:0] pat_d [PATTERN_LEN-1:0];
    logic [2:0]         len_q, len_d;
    logic [2:0]         idx_q, idx_d;
    logic [2:0]         next_ball_q, next_ball_d;
    logic               valid_q, valid_d;
    logic [2:0]         height_q, height_d;
    logic [2:0]         ball_q, ball_d;
    logic               empty_q, empty_d;
    logic [2:0]         tidx_q, tidx_d;
    logic               err_q, err_d;

    logic               start_ok, start_bad, beat_go, beat_fault, beat_ok;
    logic               land, need_new, dropped, exhausted, collide;
    logic [THROW_W-1:0] h;
    logic [2:0]         thrower;
    slot_t              slot0;

    always_comb begin
        h          = pat_q[idx_q];
        land       = slot0.occ;
        need_new   = !land && (h != '0);
        dropped    = land && (h == '0);
        exhausted  = need_new && (next_ball_q == 3'(MAX_BALLS));
        thrower    = land ? slot0.ball_id : next_ball_q;
        start_ok   = (state_q == IDLE) && bus.start_in && !bus.stop_in &&
                     bus.pattern_valid_in && (bus.pattern_length != '0);
        start_bad  = (state_q == IDLE) && bus.start_in && !bus.stop_in && !start_ok;
        // stop_in wins over a simultaneous beat, so the beat is simply dropped.
        beat_go    = (state_q == RUN) && bus.beat_in && !bus.stop_in;
        beat_fault = beat_go && (collide || dropped || exhausted);
        beat_ok    = beat_go && !beat_fault;
    end

    landing_table u_table (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clear_in   (bus.stop_in || start_ok),
        .shift_en   (beat_ok),
        .place_h    (h),
        .place_ball (thrower),
        .slot0      (slot0),
        .collide    (collide)
`ifdef LANDING_MASK_EN
        , .occ_mask (bus.landing_mask_out)
`endif
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.stop_in)     state_d = IDLE;
        else if (start_ok)   state_d = RUN;
        else if (beat_fault) state_d = FAULT;
    end

    always_comb begin
        pat_d       = pat_q;
        len_d       = len_q;
        idx_d       = idx_q;
        next_ball_d = next_ball_q;
        valid_d     = 1'b0;
        height_d    = height_q;
        ball_d      = ball_q;
        empty_d     = empty_q;
        tidx_d      = tidx_q;
        err_d       = start_bad;
        if (bus.stop_in) begin
            idx_d       = '0;
            next_ball_d = '0;
            height_d    = '0;
            ball_d      = '0;
            empty_d     = 1'b0;
            tidx_d      = '0;
        end else if (start_ok) begin
            pat_d       = bus.pattern_in;
            len_d       = bus.pattern_length;
            idx_d       = '0;
            next_ball_d = '0;
        end else if (beat_ok) begin
            valid_d     = 1'b1;
            height_d    = h;
            ball_d      = (h == '0) ? 3'd0 : thrower;
            empty_d     = (h == '0);
            tidx_d      = idx_q;
            idx_d       = (idx_q == len_q - 3'd1) ? 3'd0 : idx_q + 3'd1;
            if (need_new) next_ball_d = next_ball_q + 3'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int j = 0; j < PATTERN_LEN; j++) pat_q[j] <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            next_ball_q <= '0;
            valid_q     <= 1'b0;
            height_q    <= '0;
            ball_q      <= '0;
            empty_q     <= 1'b0;
            tidx_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            pat_q       <= pat_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            next_ball_q <= next_ball_d;
            valid_q     <= valid_d;
            height_q    <= height_d;
            ball_q      <= ball_d;
            empty_q     <= empty_d;
            tidx_q      <= tidx_d;
            err_q       <= err_d;
        end
    end

    assign bus.busy_out         = (state_q == RUN);
    assign bus.fault_out        = (state_q == FAULT);
    assign bus.start_err_out    = err_q;
    assign bus.throw_valid_out  = valid_q;
    assign bus.throw_height_out = height_q;
    assign bus.throw_ball_out   = ball_q;
    assign bus.throw_empty_out  = empty_q;
    assign bus.throw_index_out  = tidx_q;
    assign bus.num_balls_out    = next_ball_q;
    assign bus.state_dbg        = state_q;
endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: expected throws are queued by the driver and
// popped/compared by a monitor whenever throw_valid_out is seen.
module tb_pattern_sequencer;
    import juggle_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pattern_sequencer_if bus ();

    pattern_sequencer dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];

    function automatic logic [12:0] rec(int hh, int bb, int ee, int ii, int nn);
        return {3'(hh), 3'(bb), 1'(ee), 3'(ii), 3'(nn)};
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares each presented throw with the oldest queued expectation.
    always @(negedge clk) begin
        logic [12:0] act;
        logic [12:0] e;
        if (!rst && bus.throw_valid_out) begin
            act = {bus.throw_height_out, bus.throw_ball_out, bus.throw_empty_out,
                   bus.throw_index_out, bus.num_balls_out};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_throw: got %h expected none", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL throw: got h%0d b%0d e%0d i%0d n%0d expected h%0d b%0d e%0d i%0d n%0d",
                             act[12:10], act[9:7], act[6], act[5:3], act[2:0],
                             e[12:10], e[9:7], e[6], e[5:3], e[2:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pat(input int p0, input int p1, input int p2, input int len);
        for (int j = 0; j < PATTERN_LEN; j++) bus.pattern_in[j] = '0;
        bus.pattern_in[0]    = 3'(p0);
        bus.pattern_in[1]    = 3'(p1);
        bus.pattern_in[2]    = 3'(p2);
        bus.pattern_length   = 3'(len);
        bus.pattern_valid_in = 1'b1;
        bus.start_in         = 1'b1;
        cyc();
        bus.start_in = 1'b0;
        check("busy_after_start", int'(bus.busy_out), 1);
        check("state_after_start", int'(bus.state_dbg), int'(RUN));
    endtask

    task automatic beat(input bit expect_out, input logic [12:0] e);
        if (expect_out) exp_q.push_back(e);
        bus.beat_in = 1'b1;
        cyc();
        bus.beat_in = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic stop_now();
        bus.stop_in = 1'b1;
        cyc();
        bus.stop_in = 1'b0;
        cyc();
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_valid"}, int'(bus.throw_valid_out), 0);
        check({tag, "_busy"},  int'(bus.busy_out), 0);
        check({tag, "_fault"}, int'(bus.fault_out), 0);
        check({tag, "_height"}, int'(bus.throw_height_out), 0);
        check({tag, "_ball"},  int'(bus.throw_ball_out), 0);
        check({tag, "_empty"}, int'(bus.throw_empty_out), 0);
        check({tag, "_index"}, int'(bus.throw_index_out), 0);
        check({tag, "_nballs"}, int'(bus.num_balls_out), 0);
    endtask

    initial begin
        logic [12:0] none;
        int b3 [7];
        none = '0;
        b3 = '{0, 1, 2, 0, 1, 2, 0};
        for (int j = 0; j < PATTERN_LEN; j++) bus.pattern_in[j] = '0;
        bus.pattern_length   = '0;
        bus.pattern_valid_in = 1'b0;
        bus.start_in         = 1'b0;
        bus.stop_in          = 1'b0;
        bus.beat_in          = 1'b0;
        repeat (3) cyc();
        check_all_zero("reset");
        check("reset_err", int'(bus.start_err_out), 0);
        rst = 1'b0;
        cyc();

        // Cascade "3": three balls cycle 0,1,2.
        start_pat(3, 0, 0, 1);
        for (int k = 0; k < 7; k++) beat(1'b1, rec(3, b3[k], 0, 0, (k < 2) ? k + 1 : 3));
        check("p3_nballs", int'(bus.num_balls_out), 3);
        check("p3_fault", int'(bus.fault_out), 0);
`ifdef LANDING_MASK_EN
        check("p3_mask", int'(bus.landing_mask_out), 7);
`endif
        // stop_in together with beat_in: beat dropped, back to IDLE.
        bus.stop_in = 1'b1;
        bus.beat_in = 1'b1;
        cyc();
        bus.stop_in = 1'b0;
        bus.beat_in = 1'b0;
        check("stopbeat_valid", int'(bus.throw_valid_out), 0);
        check("stopbeat_busy", int'(bus.busy_out), 0);
        check("stopbeat_nballs", int'(bus.num_balls_out), 0);
        cyc();

        // "531"
        start_pat(5, 3, 1, 3);
        beat(1'b1, rec(5, 0, 0, 0, 1));
        beat(1'b1, rec(3, 1, 0, 1, 2));
        beat(1'b1, rec(1, 2, 0, 2, 3));
        beat(1'b1, rec(5, 2, 0, 0, 3));
        beat(1'b1, rec(3, 1, 0, 1, 3));
        beat(1'b1, rec(1, 0, 0, 2, 3));
        check("p531_nballs", int'(bus.num_balls_out), 3);
        stop_now();

        // "501": empty hand on the second beat, ball 1 appears on the third.
        start_pat(5, 0, 1, 3);
        beat(1'b1, rec(5, 0, 0, 0, 1));
        beat(1'b1, rec(0, 0, 1, 1, 1));
        beat(1'b1, rec(1, 1, 0, 2, 2));
        check("p501_nballs", int'(bus.num_balls_out), 2);
        stop_now();

        // "21": second beat collides.
        start_pat(2, 1, 0, 2);
        beat(1'b1, rec(2, 0, 0, 0, 1));
        bus.beat_in = 1'b1;
        cyc();
        bus.beat_in = 1'b0;
        check("p21_fault", int'(bus.fault_out), 1);
        check("p21_busy", int'(bus.busy_out), 0);
        check("p21_state", int'(bus.state_dbg), int'(FAULT));
        cyc();
        beat(1'b0, none);
        beat(1'b0, none);
        check("p21_fault_hold", int'(bus.fault_out), 1);
        bus.stop_in = 1'b1;
        cyc();
        bus.stop_in = 1'b0;
        check_all_zero("p21_stop");
        cyc();

        // Rejected starts.
        bus.pattern_valid_in = 1'b0;
        bus.pattern_length   = 3'd2;
        bus.start_in         = 1'b1;
        cyc();
        bus.start_in = 1'b0;
        check("badvalid_err", int'(bus.start_err_out), 1);
        check("badvalid_busy", int'(bus.busy_out), 0);
        cyc();
        check("badvalid_err_end", int'(bus.start_err_out), 0);
        bus.pattern_valid_in = 1'b1;
        bus.pattern_length   = 3'd0;
        bus.start_in         = 1'b1;
        cyc();
        bus.start_in = 1'b0;
        check("badlen_err", int'(bus.start_err_out), 1);
        check("badlen_state", int'(bus.state_dbg), int'(IDLE));
        cyc();
        check("badlen_err_end", int'(bus.start_err_out), 0);

        // Reset mid-RUN of "531", then restart from ball 0, index 0.
        start_pat(5, 3, 1, 3);
        beat(1'b1, rec(5, 0, 0, 0, 1));
        beat(1'b1, rec(3, 1, 0, 1, 2));
        rst = 1'b1;
        bus.beat_in = 1'b1;
        cyc();
        rst = 1'b0;
        bus.beat_in = 1'b0;
        check_all_zero("midrst");
        cyc();
        start_pat(5, 3, 1, 3);
        beat(1'b1, rec(5, 0, 0, 0, 1));
        beat(1'b1, rec(3, 1, 0, 1, 2));
        stop_now();

        check("pending_expected", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
